// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the tiny16 memory/I-O responder: I/O map,
// STATUS bit layout and transmitter state encodings.
package mem_io_responder_pkg;

    // I/O page: any address whose upper byte is 8'hFF
    localparam logic [7:0]  IO_PAGE      = 8'hFF;
    localparam logic [15:0] IO_TXDATA    = 16'hFFF0;
    localparam logic [15:0] IO_STATUS    = 16'hFFF1;

    // STATUS register bit positions
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 6;

    // Serial transmitter states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mem_io_responder_uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, one stop bit,
// each BAUD_DIV clocks long. Takes a byte when idle and valid is high.
module uart_tx
    import mem_io_responder_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    // Frame sequencer with registered line and busy outputs; the baud
    // counter restarts at 0 on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_baud <= '0;
                    if (valid) begin
                        r_shift <= data;
                        r_state <= TX_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                TX_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                TX_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= TX_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = (r_state == TX_IDLE);
    assign tx    = r_tx;
    assign busy  = r_busy;

endmodule

// File: rtl/mem_io_responder.sv
// Bus-side responder: address latch, RAM, memory-mapped I/O page and a
// small TX FIFO draining into the serial transmitter.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        mem_addr_en,
    input  logic        mem_in_en,
    input  logic        mem_out_en,
    input  logic        dsp_in_en,
    output logic [15:0] bus_out,
    output logic        bus_out_en,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [15:0]      r_addr_q;
    logic [15:0]      r_ram [2**ADDR_W];
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic        w_io_sel;
    logic        w_tx_wr;
    logic        w_status_rd;
    logic        w_push_req;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_ready;
    logic        w_busy;
    logic [15:0] w_status;
    logic [15:0] w_ram_rd;
    logic [15:0] w_io_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Decode against the address latched before this cycle's edge
    assign w_io_sel    = (r_addr_q[15:8] == IO_PAGE);
    assign w_tx_wr     = mem_in_en  && (r_addr_q == IO_TXDATA);
    assign w_status_rd = mem_out_en && (r_addr_q == IO_STATUS);

    // Simultaneous TXDATA write and display strobe collapse into one push
    assign w_push_req = dsp_in_en || w_tx_wr;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = w_ready && !w_empty;

    // Address latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_addr_q <= '0;
        else if (mem_addr_en) r_addr_q <= bus_in;
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_in_en && !w_io_sel) r_ram[r_addr_q[ADDR_W-1:0]] <= bus_in;
    end

    // FIFO storage; only the slot being written changes
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus_in[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a new drop beats a clearing read)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            if (w_drop)           r_ovf <= 1'b1;
            else if (w_status_rd) r_ovf <= 1'b0;
        end
    end

    // STATUS register image
    always_comb begin
        w_status                          = '0;
        w_status[ST_EMPTY_BIT]            = w_empty;
        w_status[ST_FULL_BIT]             = w_full;
        w_status[ST_BUSY_BIT]             = w_busy;
        w_status[ST_OVF_BIT]              = r_ovf;
        w_status[ST_CNT_MSB:ST_CNT_LSB]   = 3'(r_count);
    end

    // Read mux: RAM or I/O page, forced to zero when not reading
    always_comb begin
        w_ram_rd = r_ram[r_addr_q[ADDR_W-1:0]];
        w_io_rd  = (r_addr_q == IO_STATUS) ? w_status : 16'h0000;
        bus_out  = 16'h0000;
        if (mem_out_en) bus_out = w_io_sel ? w_io_rd : w_ram_rd;
    end

    assign bus_out_en = mem_out_en;
    assign tx_busy    = w_busy;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (r_fifo[r_rd_ptr]),
        .valid (!w_empty),
        .ready (w_ready),
        .tx    (tx),
        .busy  (w_busy)
    );

endmodule
